t07_mem_sequencer: RTL

Parametrised CPU memory sequencer for the team 07 core. It sequences instruction fetch and load/store phases against the MMIO bus using a busy-falling-edge completion handshake. It supports configurable bus width with byte-lane steering and write strobes, misalignment detection, and a busy watchdog with a sticky fault state. It sits between the control unit/ALU/FPU register file and the MMIO bus controller, and drives the CPU freeze line.

---
 rtl/t07_mem_sequencer.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/t07_mem_sequencer.sv
// t07_mem_sequencer: sequences instruction fetch and load/store phases
// against the MMIO bus. The bus signals completion with a falling edge on
// busy. The block does byte-lane steering, write strobes and misalignment
// detection, and has a busy watchdog that raises a sticky fault.
module t07_mem_sequencer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic                mem_source_i,
  input  logic [3:0]          mem_op_i,
  input  logic [ADDR_W-1:0]   alu_addr_i,
  input  logic [31:0]         fpu_data_i,
  input  logic [31:0]         reg_data_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_busy_i,
  input  logic                fault_clr_i,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  output logic [1:0]          rwi_o,
  output logic                addr_sel_o,
  output logic [31:0]         instr_o,
  output logic                instr_valid_o,
  output logic [31:0]         reg_data_o,
  output logic                reg_we_o,
  output logic                freeze_o,
  output logic                fault_o,
  output logic [1:0]          fault_code_o
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LANE_MASK = ~ADDR_W'(NB - 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_F_WAIT = 3'd1,
    S_EXEC   = 3'd2,
    S_D_WAIT = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic               prev_busy;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [OFF_W-1:0]   off_q, off_n;
  logic [3:0]         op_q, op_n;

  logic [ADDR_W-1:0]  bus_addr_n;
  logic [DATA_W-1:0]  wdata_n;
  logic [NB-1:0]      wstrb_n;
  logic [1:0]         rwi_n, code_n;
  logic               addr_sel_n, instr_valid_n, reg_we_n, freeze_n, fault_n;
  logic [31:0]        instr_n, reg_data_n;

  // Completion: registered-busy falling edge, ignored in a wait's first cycle
  logic bus_done, timed_out;
  assign bus_done  = prev_busy & ~bus_busy_i & (cnt != '0);
  assign timed_out = (cnt == CNT_LAST);

  logic [OFF_W-1:0] req_off, word_off;
  logic [31:0]      fetch_word, load_word;
  assign req_off    = alu_addr_i[OFF_W-1:0];
  assign word_off   = off_q & ~OFF_W'(3);
  assign fetch_word = 32'(bus_rdata_i >> {word_off, 3'b000});
  assign load_word  = 32'(bus_rdata_i >> {off_q, 3'b000});

  // Sign/zero extension of the lane-shifted load data
  logic [31:0] load_ext;
  always_comb begin
    case (op_q)
      OP_LB:   load_ext = {{24{load_word[7]}}, load_word[7:0]};
      OP_LH:   load_ext = {{16{load_word[15]}}, load_word[15:0]};
      OP_LBU:  load_ext = {24'b0, load_word[7:0]};
      OP_LHU:  load_ext = {16'b0, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

  // Request decode: store wins over load, and the op must match the direction
  logic        is_store, req_valid, misaligned;
  logic [1:0]  req_size;
  logic [31:0] st_src, st_masked;
  logic [DATA_W-1:0] st_wdata;
  logic [NB-1:0]     st_wstrb;
  always_comb begin
    is_store  = mem_write_i;
    req_valid = 1'b0;
    req_size  = 2'd0;
    if (mem_write_i) begin
      case (mem_op_i)
        OP_SB:   begin req_valid = 1'b1; req_size = 2'd0; end
        OP_SH:   begin req_valid = 1'b1; req_size = 2'd1; end
        OP_SW:   begin req_valid = 1'b1; req_size = 2'd2; end
        default: req_valid = 1'b0;
      endcase
    end else if (mem_read_i) begin
      case (mem_op_i)
        OP_LB, OP_LBU: begin req_valid = 1'b1; req_size = 2'd0; end
        OP_LH, OP_LHU: begin req_valid = 1'b1; req_size = 2'd1; end
        OP_LW:         begin req_valid = 1'b1; req_size = 2'd2; end
        default:       req_valid = 1'b0;
      endcase
    end
    misaligned = ((req_size == 2'd1) && req_off[0]) ||
                 ((req_size == 2'd2) && (req_off[1:0] != 2'b00));
    st_src = mem_source_i ? fpu_data_i : reg_data_i;
    case (req_size)
      2'd0:    st_masked = {24'b0, st_src[7:0]};
      2'd1:    st_masked = {16'b0, st_src[15:0]};
      default: st_masked = st_src;
    endcase
    st_wdata = DATA_W'(st_masked) << {req_off, 3'b000};
    case (req_size)
      2'd0:    st_wstrb = NB'(4'b0001) << req_off;
      2'd1:    st_wstrb = NB'(4'b0011) << req_off;
      default: st_wstrb = NB'(4'b1111) << req_off;
    endcase
  end

  // Next-state and next-output computation
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    off_n         = off_q;
    op_n          = op_q;
    bus_addr_n    = bus_addr_o;
    wdata_n       = bus_wdata_o;
    wstrb_n       = bus_wstrb_o;
    rwi_n         = rwi_o;
    addr_sel_n    = addr_sel_o;
    instr_n       = instr_o;
    instr_valid_n = 1'b0;
    reg_data_n    = reg_data_o;
    reg_we_n      = 1'b0;
    freeze_n      = freeze_o;
    fault_n       = fault_o;
    code_n        = fault_code_o;
    case (state)
      S_FETCH: begin
        state_n    = S_F_WAIT;
        cnt_n      = '0;
        bus_addr_n = pc_i & LANE_MASK;
        off_n      = pc_i[OFF_W-1:0];
        wdata_n    = '0;
        wstrb_n    = '0;
        rwi_n      = 2'b11;
        addr_sel_n = 1'b1;
        freeze_n   = 1'b1;
      end
      S_F_WAIT: begin
        cnt_n = cnt + CNT_W'(1);
        if (bus_done) begin
          state_n       = S_EXEC;
          instr_n       = fetch_word;
          instr_valid_n = 1'b1;
          rwi_n         = 2'b00;
          freeze_n      = 1'b0;
        end else if (timed_out) begin
          state_n = S_FAULT;
          rwi_n   = 2'b00;
          fault_n = 1'b1;
          code_n  = 2'b10;
        end
      end
      S_EXEC: begin
        state_n    = S_FETCH;
        rwi_n      = 2'b00;
        freeze_n   = 1'b1;
        addr_sel_n = 1'b1;
        if (req_valid) begin
          if (misaligned) begin
            state_n = S_FAULT;
            fault_n = 1'b1;
            code_n  = 2'b01;
          end else begin
            state_n    = S_D_WAIT;
            cnt_n      = '0;
            bus_addr_n = alu_addr_i & LANE_MASK;
            off_n      = req_off;
            op_n       = mem_op_i;
            addr_sel_n = 1'b0;
            if (is_store) begin
              rwi_n   = 2'b01;
              wdata_n = st_wdata;
              wstrb_n = st_wstrb;
            end else begin
              rwi_n   = 2'b10;
              wdata_n = '0;
              wstrb_n = '0;
            end
          end
        end
      end
      S_D_WAIT: begin
        cnt_n = cnt + CNT_W'(1);
        if (bus_done) begin
          state_n    = S_FETCH;
          rwi_n      = 2'b00;
          addr_sel_n = 1'b1;
          wstrb_n    = '0;
          if (rwi_o == 2'b10) begin
            reg_data_n = load_ext;
            reg_we_n   = 1'b1;
          end
        end else if (timed_out) begin
          state_n = S_FAULT;
          rwi_n   = 2'b00;
          wstrb_n = '0;
          fault_n = 1'b1;
          code_n  = 2'b11;
        end
      end
      S_FAULT: begin
        rwi_n    = 2'b00;
        freeze_n = 1'b1;
        if (fault_clr_i) begin
          state_n = S_FETCH;
          fault_n = 1'b0;
          code_n  = 2'b00;
        end
      end
      default: state_n = S_FETCH;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state         <= S_FETCH;
      prev_busy     <= 1'b0;
      cnt           <= '0;
      off_q         <= '0;
      op_q          <= '0;
      bus_addr_o    <= '0;
      bus_wdata_o   <= '0;
      bus_wstrb_o   <= '0;
      rwi_o         <= 2'b00;
      addr_sel_o    <= 1'b1;
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
      reg_data_o    <= '0;
      reg_we_o      <= 1'b0;
      freeze_o      <= 1'b1;
      fault_o       <= 1'b0;
      fault_code_o  <= 2'b00;
    end else begin
      state         <= state_n;
      prev_busy     <= bus_busy_i;
      cnt           <= cnt_n;
      off_q         <= off_n;
      op_q          <= op_n;
      bus_addr_o    <= bus_addr_n;
      bus_wdata_o   <= wdata_n;
      bus_wstrb_o   <= wstrb_n;
      rwi_o         <= rwi_n;
      addr_sel_o    <= addr_sel_n;
      instr_o       <= instr_n;
      instr_valid_o <= instr_valid_n;
      reg_data_o    <= reg_data_n;
      reg_we_o      <= reg_we_n;
      freeze_o      <= freeze_n;
      fault_o       <= fault_n;
      fault_code_o  <= code_n;
    end
  end

endmodule
